iter_md_unit: RTL and testbench
===============================

ITER_MD_UNIT -- requirements
Module: iter_md_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width (even, >=8).
REQ-002 Parameter OPW, default 4, width of op code.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req  input  1  exception/interrupt flush; cancels start, writes and in-flight operation.
REQ-006 start  input  1  launch multiply/divide given by op.
REQ-007 op  input  OPW  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO; others no-op.
REQ-008 md_write  input  1  qualifies MTHI/MTLO.
REQ-009 md_sel  input  1  read select: 0 LO, 1 HI.
REQ-010 a  input  WIDTH  operand 1 (multiplicand/dividend, MTHI/MTLO data).
REQ-011 b  input  WIDTH  operand 2 (multiplier/divisor).
REQ-012 busy  output  1  operation in flight.
REQ-013 done  output  1  one-cycle pulse on the cycle HI/LO are written by an operation.
REQ-014 result  output  WIDTH  md_sel ? HI : LO, combinational from registers.

Function
REQ-015 FSM states IDLE, RUN, FIX; busy SHALL be 1 exactly in RUN and FIX.
REQ-016 IDLE: start=1, req=0, op in 0..7 -> RUN; latch op, |a|,|b| (signed ops) or a,b, signs, count=WIDTH.
REQ-017 RUN: one radix-2 iteration per cycle (shift-add multiply, restoring divide on magnitudes); count decrements; count==1 -> FIX.
REQ-018 FIX: apply sign correction, accumulate, write HI/LO, pulse done, -> IDLE; busy=0 and new result visible the next cycle after FIX.
REQ-019 Latency: busy high WIDTH+1 consecutive cycles starting cycle after start accepted (33 at WIDTH=32).
REQ-020 MULT/MULTU: {HI,LO} = a*b, 2*WIDTH-bit signed/unsigned product.
REQ-021 MADD(U)/MSUB(U): {HI,LO} = {HI,LO} +/- a*b, modulo 2^(2*WIDTH), using HI/LO as of FIX.
REQ-022 DIV: LO = quotient truncated toward zero, HI = remainder with dividend's sign; DIVU unsigned.
REQ-023 Divide by zero: LO = all ones, HI = a; no trap.
REQ-024 DIV overflow (a = most negative, b = -1): LO = a, HI = 0.
REQ-025 start while busy: ignored; caller must stall on busy.
REQ-026 MTHI/MTLO: when md_write=1, req=0, busy=0, HI (resp. LO) <= a next edge; ignored while busy.
REQ-027 req=1 in any state: start and MTHI/MTLO ignored; RUN/FIX abort to IDLE next edge, HI/LO unchanged, no done.
REQ-028 start with op 8..15: no state change.
REQ-029 Operand inputs need only be valid in the start cycle; a/b changes during RUN have no effect.

Reset
REQ-030 On reset: state IDLE, HI=0, LO=0, count=0, busy=0, done=0, result=0; reset overrides req and start.
REQ-031 Reset mid-operation aborts it; no HI/LO write.

Verification
REQ-032 MTLO a=10, then MADD a=3 b=4 -> done after 33 busy cycles, HI=0, LO=22.
REQ-033 MULT a=0xFFFFFFFF b=2 -> HI=0xFFFFFFFF LO=0xFFFFFFFE; MULTU same -> HI=1 LO=0xFFFFFFFE.
REQ-034 DIV a=-7 b=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU a=5 b=0 -> LO=0xFFFFFFFF HI=5; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000 HI=0.
REQ-035 HI=LO=0x1234, MULTU started, req=1 in 10th busy cycle -> busy=0 next cycle, no done, HI=LO=0x1234; start while busy ignored.
REQ-036 WIDTH=8: MULTU 0xFF*0xFF -> busy 9 cycles, HI=0xFE LO=0x01.
REQ-037 reset asserted during RUN -> next cycle busy=0, HI=LO=0, result=0.

Source files
------------

// File: rtl/iter_md_unit.sv
// Iterative multiply/divide unit with HI/LO registers: radix-2 shift-add multiply,
// restoring divide on magnitudes, multiply-accumulate and MTHI/MTLO writes.
module iter_md_unit #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             start,
  input  logic [OPW-1:0]   op,
  input  logic             md_write,
  input  logic             md_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [OPW-1:0] OP_MTHI = OPW'(8);
  localparam logic [OPW-1:0] OP_MTLO = OPW'(9);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state;
  logic [WIDTH-1:0]     hi, lo;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   p;
  logic [CW-1:0]        count;
  logic [2:0]           op_q;
  logic                 neg_q, neg_rem_q, dz_q;

  logic                 op_md, op_signed, op_div, a_neg, b_neg;
  logic                 is_div_q;
  logic [WIDTH:0]       mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0]   mul_next, div_next;
  logic [2*WIDTH-1:0]   prod, acc, mac;
  logic [WIDTH-1:0]     quo, rem, div_lo, div_hi;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign op_md     = (op < OPW'(8));
  assign op_signed = ~op[0];
  assign op_div    = (op[2:1] == 2'b01);
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];
  assign is_div_q  = (op_q[2:1] == 2'b01);

  // p holds {partial_hi, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mcand} : '0);
    mul_next = {mul_sum, p[WIDTH-1:1]};
    div_sh   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    div_diff = div_sh - {1'b0, mcand};
    if (!div_diff[WIDTH])
      div_next = {div_diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    else
      div_next = {div_sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    prod = neg_q ? -p : p;
    acc  = {hi, lo};
    if (op_q[2])
      mac = op_q[1] ? (acc - prod) : (acc + prod);
    else
      mac = prod;
    quo    = p[WIDTH-1:0];
    rem    = p[2*WIDTH-1:WIDTH];
    // Divide by zero leaves the dividend magnitude in rem, so HI = a falls out naturally.
    div_lo = dz_q ? '1 : (neg_q ? -quo : quo);
    div_hi = neg_rem_q ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hi        <= '0;
      lo        <= '0;
      mcand     <= '0;
      p         <= '0;
      count     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (!req) begin
            if (start && op_md) begin
              state     <= RUN;
              busy      <= 1'b1;
              op_q      <= op[2:0];
              count     <= CW'(WIDTH);
              neg_q     <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              dz_q      <= (b == '0);
              if (op_div) begin
                p     <= {{WIDTH{1'b0}}, mag(a, a_neg)};
                mcand <= mag(b, b_neg);
              end else begin
                p     <= {{WIDTH{1'b0}}, mag(b, b_neg)};
                mcand <= mag(a, a_neg);
              end
            end else if (md_write && op == OP_MTHI) begin
              hi <= a;
            end else if (md_write && op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        RUN: begin
          if (req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            p     <= is_div_q ? div_next : mul_next;
            count <= count - CW'(1);
            if (count == CW'(1))
              state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!req) begin
            done <= 1'b1;
            if (is_div_q) begin
              hi <= div_hi;
              lo <= div_lo;
            end else begin
              hi <= mac[2*WIDTH-1:WIDTH];
              lo <= mac[WIDTH-1:0];
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign result = md_sel ? hi : lo;

endmodule

// File: tb/tb_iter_md_unit.sv
// Scoreboard bench for iter_md_unit: 32-bit instance for the full op set, 8-bit instance for latency scaling.
module tb_iter_md_unit;

  logic        clk = 1'b0;
  logic        reset, req, start, md_write, md_sel;
  logic [3:0]  op;
  logic [31:0] a, b, result;
  logic        busy, done;

  logic        start8, md_sel8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, result8;
  logic        busy8, done8;

  logic [63:0] sb_q[$];
  logic [31:0] m_hi, m_lo;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  iter_md_unit #(.WIDTH(32), .OPW(4)) u_dut (
    .clk(clk), .reset(reset), .req(req), .start(start), .op(op),
    .md_write(md_write), .md_sel(md_sel), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  iter_md_unit #(.WIDTH(8), .OPW(4)) u_dut8 (
    .clk(clk), .reset(reset), .req(1'b0), .start(start8), .op(op8),
    .md_write(1'b0), .md_sel(md_sel8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8)
  );

  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x, y,
                                        input logic [31:0] h, l);
    longint      sx, sy;
    logic [63:0] pr;
    int          qi, ri;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      4'd0, 4'd4, 4'd6: pr = 64'(sx * sy);
      4'd1, 4'd5, 4'd7: pr = {32'd0, x} * {32'd0, y};
      default:          pr = '0;
    endcase
    case (o)
      4'd0, 4'd1: return pr;
      4'd4, 4'd5: return {h, l} + pr;
      4'd6, 4'd7: return {h, l} - pr;
      4'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, x};
        qi = $signed(x) / $signed(y);
        ri = $signed(x) % $signed(y);
        return {32'(ri), 32'(qi)};
      end
      4'd3: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return {h, l};
    endcase
  endfunction

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    md_sel = 1'b1; #1 h = result;
    md_sel = 1'b0; #1 l = result;
  endtask

  task automatic write_md(input logic [3:0] o, input logic [31:0] d);
    op = o; a = d; md_write = 1'b1;
    @(posedge clk); #1;
    md_write = 1'b0;
    if (o == 4'd8) m_hi = d; else m_lo = d;
  endtask

  // Drives one operation, optionally pokes an MTLO mid-flight, waits (bounded) for done.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, y, input int mt_at,
                        output int bcnt, output bit seen);
    sb_q.push_back(model(o, x, y, m_hi, m_lo));
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom_range(0, 7));
    bcnt = 0; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) bcnt++;
      if (mt_at > 0 && i == mt_at) begin md_write = 1'b1; op = 4'd9; a = 32'hDEAD_BEEF; end
      else md_write = 1'b0;
      @(posedge clk); #1;
    end
    md_write = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] h, l;
    reset = 1'b1; req = 1'b1; start = 1'b1; op = 4'd0; md_write = 1'b1; md_sel = 1'b0;
    a = 32'h55; b = 32'h3; start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; md_sel8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req = 1'b0; start = 1'b0; md_write = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    read_hilo(h, l);
    n_cmp++; if (h !== 32'd0) begin n_err++; $display("FAIL reset_hi got %h want 0", h); end
    n_cmp++; if (l !== 32'd0) begin n_err++; $display("FAIL reset_lo got %h want 0", l); end
    reset = 1'b0;
    @(posedge clk); #1;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_madd;
    logic [31:0] h, l;
    logic [63:0] exp;
    int bc; bit seen;
    write_md(4'd9, 32'd10);
    read_hilo(h, l);
    n_cmp++; if (l !== 32'd10) begin n_err++; $display("FAIL mtlo got %h want 0000000a", l); end
    run_op(4'd4, 32'd3, 32'd4, 0, bc, seen);
    n_cmp++; if (!seen) begin n_err++; $display("FAIL madd_done timeout got 0 want 1"); end
    n_cmp++; if (bc != 33) begin n_err++; $display("FAIL madd_busy got %0d want 33", bc); end
    exp = sb_q.pop_front();
    read_hilo(h, l);
    n_cmp++; if ({h, l} !== exp) begin n_err++; $display("FAIL madd_hilo got %h want %h", {h, l}, exp); end
    n_cmp++; if (l !== 32'd22) begin n_err++; $display("FAIL madd_lo22 got %0d want 22", l); end
    m_hi = exp[63:32]; m_lo = exp[31:0];
  endtask

  task automatic test_directed;
    logic [3:0]  ops[5]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd2};
    logic [31:0] as[5]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
    logic [31:0] bs[5]   = '{32'd2, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [63:0] want[5] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0001_FFFF_FFFE,
                             64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0005_FFFF_FFFF,
                             64'h0000_0000_8000_0000};
    logic [31:0] h, l;
    logic [63:0] exp;
    int bc; bit seen;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], 0, bc, seen);
      n_cmp++; if (!seen || bc != 33) begin n_err++; $display("FAIL dir%0d_latency got %0d/%b want 33/1", i, bc, seen); end
      exp = sb_q.pop_front();
      read_hilo(h, l);
      n_cmp++; if ({h, l} !== want[i] || exp !== want[i]) begin
        n_err++; $display("FAIL dir%0d_hilo got %h want %h", i, {h, l}, want[i]);
      end
      m_hi = exp[63:32]; m_lo = exp[31:0];
    end
  endtask

  task automatic test_random;
    logic [31:0] h, l, x, y;
    logic [3:0]  o;
    logic [63:0] exp;
    int bc; bit seen;
    for (int i = 0; i < 12; i++) begin
      o = 4'(i % 8);
      x = $urandom;
      y = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      if (i % 4 == 1) x = -x;
      run_op(o, x, y, 0, bc, seen);
      exp = sb_q.pop_front();
      read_hilo(h, l);
      n_cmp++; if (!seen || {h, l} !== exp) begin
        n_err++; $display("FAIL rand%0d_op%0d got %h want %h (done %b)", i, o, {h, l}, exp, seen);
      end
      m_hi = exp[63:32]; m_lo = exp[31:0];
    end
  endtask

  task automatic test_abort;
    logic [31:0] h, l;
    bit stray;
    write_md(4'd8, 32'h1234);
    write_md(4'd9, 32'h1234);
    op = 4'd1; a = 32'h0001_0003; b = 32'h0000_0777; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k < 10; k++) begin
      start = (k == 3);
      if (k == 3) begin op = 4'd0; a = 32'd9; b = 32'd9; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy10 got %b want 1", busy); end
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL abort_flush got busy %b done %b want 0 0", busy, done);
    end
    stray = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy || done) stray = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++; if (stray) begin n_err++; $display("FAIL abort_quiet got activity want none"); end
    read_hilo(h, l);
    n_cmp++; if (h !== 32'h1234 || l !== 32'h1234) begin
      n_err++; $display("FAIL abort_hilo got %h %h want 00001234 00001234", h, l);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] h, l;
    logic [63:0] exp;
    int bc; bit seen;
    op = 4'd12; start = 1'b1; a = 32'd7; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL noop_start got busy %b want 0", busy); end
    run_op(4'd5, 32'hFFFF_0001, 32'h0001_0000, 7, bc, seen);
    exp = sb_q.pop_front();
    read_hilo(h, l);
    n_cmp++; if (!seen || {h, l} !== exp) begin
      n_err++; $display("FAIL b2b_maddu got %h want %h", {h, l}, exp);
    end
    m_hi = exp[63:32]; m_lo = exp[31:0];
    run_op(4'd7, 32'h0000_1000, 32'h0000_0003, 0, bc, seen);
    exp = sb_q.pop_front();
    read_hilo(h, l);
    n_cmp++; if (!seen || bc != 33 || {h, l} !== exp) begin
      n_err++; $display("FAIL b2b_msubu got %h want %h (busy %0d)", {h, l}, exp, bc);
    end
    m_hi = exp[63:32]; m_lo = exp[31:0];
  endtask

  task automatic test_reset_mid;
    logic [31:0] h, l;
    bit stray;
    op = 4'd0; a = 32'h0123_4567; b = 32'h89AB_CDEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
    read_hilo(h, l);
    n_cmp++; if (h !== 32'd0 || l !== 32'd0 || result !== 32'd0) begin
      n_err++; $display("FAIL rstmid_hilo got %h %h want 0 0", h, l);
    end
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    stray = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) stray = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++; if (stray) begin n_err++; $display("FAIL rstmid_nodone got done want none"); end
  endtask

  task automatic test_width8;
    logic [15:0] want;
    logic [7:0]  h, l;
    int bc; bit seen;
    want = 16'(8'hFF) * 16'(8'hFF);
    op8 = 4'd1; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    bc = 0; seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (done8) begin seen = 1'b1; break; end
      if (busy8) bc++;
      @(posedge clk); #1;
    end
    n_cmp++; if (!seen || bc != 9) begin n_err++; $display("FAIL w8_busy got %0d want 9 (done %b)", bc, seen); end
    md_sel8 = 1'b1; #1 h = result8;
    md_sel8 = 1'b0; #1 l = result8;
    n_cmp++; if ({h, l} !== want) begin n_err++; $display("FAIL w8_hilo got %h want %h", {h, l}, want); end
  endtask

  initial begin
    test_reset();
    test_madd();
    test_directed();
    test_random();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
